// File: rtl/spi_bus_arbiter.sv
// Round-robin, lock-held arbiter sharing one SPI bus between NumReq host controllers.
// A guard gap with all chip selects high separates owners, and an optional watchdog revokes long grants.
module spi_bus_arbiter #(
    parameter int       NumReq        = 2,
    parameter int       CsNum         = 4,
    parameter int       GuardCycles   = 4,
    parameter int       TimeoutCycles = 0,
    parameter logic     IdleSck       = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_i,
    output logic [NumReq-1:0]         gnt_o,
    input  logic [NumReq-1:0]         req_sck_i,
    input  logic [NumReq-1:0]         req_copi_i,
    input  logic [NumReq*CsNum-1:0]   req_cs_i,
    output logic [NumReq-1:0]         req_cipo_o,
    output logic                      spi_sck_o,
    output logic                      spi_copi_o,
    output logic [CsNum-1:0]          spi_cs_o,
    input  logic                      spi_cipo_i,
    output logic [NumReq-1:0]         timeout_o,
    input  logic                      timeout_clr_i
);
    localparam int IW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int GW  = $clog2(GuardCycles + 1);
    localparam int WDW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TimeoutCycles > 0) ? WDW'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GUARD} state_e;

    state_e            r_state;
    logic [NumReq-1:0] r_gnt;
    logic [NumReq-1:0] r_timeout;
    logic [NumReq-1:0] r_lockout;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_last_owner;
    logic [GW-1:0]     r_guard;
    logic [WDW-1:0]    r_wdog;

    logic [NumReq-1:0] w_eligible;
    logic              w_found;
    logic [IW-1:0]     w_winner;
    logic              w_expire;
    logic [NumReq-1:0] w_to_set;

    assign w_eligible = req_i & ~r_lockout;

    // First eligible host searching upward from last_owner+1, wrapping modulo NumReq.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NumReq; k++) begin
            if (!w_found && w_eligible[(int'(r_last_owner) + k) % NumReq]) begin
                w_found  = 1'b1;
                w_winner = IW'((int'(r_last_owner) + k) % NumReq);
            end
        end
    end

    // A release in the expiry cycle takes precedence, so expiry requires req still high.
    assign w_expire = (TimeoutCycles > 0) && (r_state == S_OWN) && req_i[r_owner]
                      && (r_wdog == WD_LAST);
    assign w_to_set = w_expire ? (NumReq'(1) << r_owner) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= IW'(NumReq - 1);
            r_guard      <= '0;
            r_wdog       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state      <= S_OWN;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_gnt        <= NumReq'(1) << w_winner;
                        r_wdog       <= '0;
                    end
                end
                S_OWN: begin
                    if (!req_i[r_owner] || w_expire) begin
                        r_state <= S_GUARD;
                        r_gnt   <= '0;
                        r_guard <= GW'(GuardCycles - 1);
                    end else if (r_wdog != {WDW{1'b1}}) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_GUARD: begin
                    if (r_guard == '0) r_state <= S_IDLE;
                    else               r_guard <= r_guard - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Set beats clear; lockout drops once the host is seen idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timeout <= '0;
            r_lockout <= '0;
        end else begin
            r_timeout <= (timeout_clr_i ? '0 : r_timeout) | w_to_set;
            r_lockout <= (r_lockout & req_i) | w_to_set;
        end
    end

    // Bus mux is driven only from state, so reset forces the pins idle without a clock.
    always_comb begin
        spi_sck_o  = IdleSck;
        spi_copi_o = 1'b0;
        spi_cs_o   = '1;
        req_cipo_o = '0;
        if (r_state == S_OWN) begin
            spi_sck_o           = req_sck_i[r_owner];
            spi_copi_o          = req_copi_i[r_owner];
            spi_cs_o            = req_cs_i[int'(r_owner)*CsNum +: CsNum];
            req_cipo_o[r_owner] = spi_cipo_i;
        end
    end

    assign gnt_o     = r_gnt;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: grant latency, guard gap, round-robin,
// watchdog, lockout, clear/set collision and asynchronous reset.
module tb_spi_bus_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] req_i;
    logic [1:0] gnt_o;
    logic [1:0] req_sck_i;
    logic [1:0] req_copi_i;
    logic [7:0] req_cs_i;
    logic [1:0] req_cipo_o;
    logic       spi_sck_o;
    logic       spi_copi_o;
    logic [3:0] spi_cs_o;
    logic       spi_cipo_i;
    logic [1:0] timeout_o;
    logic       timeout_clr_i;

    int n_total = 0;
    int n_pass  = 0;

    spi_bus_arbiter #(
        .NumReq(2), .CsNum(4), .GuardCycles(4), .TimeoutCycles(16), .IdleSck(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .req_sck_i(req_sck_i), .req_copi_i(req_copi_i), .req_cs_i(req_cs_i),
        .req_cipo_o(req_cipo_o), .spi_sck_o(spi_sck_o), .spi_copi_o(spi_copi_o),
        .spi_cs_o(spi_cs_o), .spi_cipo_i(spi_cipo_i), .timeout_o(timeout_o),
        .timeout_clr_i(timeout_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [1:0] own;
        rst_ni = 1'b0; req_i = 2'b00; timeout_clr_i = 1'b0;
        req_sck_i = 2'b11; req_copi_i = 2'b01; req_cs_i = {4'h7, 4'hE}; spi_cipo_i = 1'b1;
        tick(); tick();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_timeout", timeout_o, 2'b00);
        chk("rst_cs", spi_cs_o, 4'hF);
        chk("rst_sck", spi_sck_o, 1'b0);
        chk("rst_copi", spi_copi_o, 1'b0);
        chk("rst_cipo", req_cipo_o, 2'b00);
        rst_ni = 1'b1;
        tick();

        // Both request from reset: host 0 wins first
        req_i = 2'b11;
        chk("pre_gnt", gnt_o, 2'b00);
        tick();
        chk("first_gnt", gnt_o, 2'b01);
        chk("own_cs", spi_cs_o, 4'hE);
        chk("own_sck", spi_sck_o, 1'b1);
        chk("own_copi", spi_copi_o, 1'b1);
        chk("own_cipo", req_cipo_o, 2'b01);
        req_cs_i[3:0] = 4'hD;
        #1 chk("cs_follow", spi_cs_o, 4'hD);
        req_cs_i[3:0] = 4'hE;

        // Host 0 releases: 5 cycles of idle bus, then host 1
        req_i = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gap_gnt", gnt_o, 2'b00);
            chk("gap_cs", spi_cs_o, 4'hF);
            chk("gap_sck", spi_sck_o, 1'b0);
        end
        tick();
        chk("second_gnt", gnt_o, 2'b10);
        chk("second_cs", spi_cs_o, 4'h7);
        chk("second_cipo", req_cipo_o, 2'b10);

        // Round robin: owner releases while the other requests, owner re-requests
        own = 2'b10;
        for (int r = 0; r < 10; r++) begin
            req_i = 2'b11 & ~own;
            tick();
            chk("rr_release", gnt_o, 2'b00);
            req_i = 2'b11;
            tick(); tick(); tick(); tick();
            chk("rr_gap", gnt_o, 2'b00);
            tick();
            own = ~own;
            chk("rr_gnt", gnt_o, own);
        end
        req_i = 2'b00;
        repeat (6) tick();
        chk("rr_idle", gnt_o, 2'b00);

        // Watchdog: host 0 holds for 16 cycles
        req_i = 2'b01;
        tick();
        chk("wd_gnt", gnt_o, 2'b01);
        repeat (15) tick();
        chk("wd_held15", gnt_o, 2'b01);
        chk("wd_noflag", timeout_o, 2'b00);
        tick();
        chk("wd_revoke", gnt_o, 2'b00);
        chk("wd_flag", timeout_o, 2'b01);
        chk("wd_cs_idle", spi_cs_o, 4'hF);
        repeat (10) tick();
        chk("lockout_gnt", gnt_o, 2'b00);
        chk("flag_sticky", timeout_o, 2'b01);
        timeout_clr_i = 1'b1;
        tick();
        timeout_clr_i = 1'b0;
        chk("flag_clr", timeout_o, 2'b00);
        req_i = 2'b00;
        tick();
        req_i = 2'b01;
        tick();
        chk("regrant", gnt_o, 2'b01);

        // Clear and new expiry in the same cycle: set wins
        repeat (15) tick();
        timeout_clr_i = 1'b1;
        tick();
        timeout_clr_i = 1'b0;
        chk("set_wins", timeout_o, 2'b01);
        chk("set_wins_gnt", gnt_o, 2'b00);
        timeout_clr_i = 1'b1;
        req_i = 2'b00;
        tick();
        timeout_clr_i = 1'b0;
        repeat (5) tick();

        // Release in the expiry cycle: normal release, guard unchanged
        req_i = 2'b01;
        tick();
        chk("sim_gnt", gnt_o, 2'b01);
        repeat (15) tick();
        req_i = 2'b00;
        tick();
        chk("sim_release", gnt_o, 2'b00);
        chk("sim_noflag", timeout_o, 2'b00);
        req_i = 2'b10;
        tick(); tick(); tick(); tick();
        chk("sim_gap", gnt_o, 2'b00);
        tick();
        chk("sim_next", gnt_o, 2'b10);

        // Asynchronous reset mid-OWN
        req_i = 2'b01;
        repeat (6) tick();
        chk("ar_gnt", gnt_o, 2'b01);
        chk("ar_cs_pre", spi_cs_o, 4'hE);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_cs", spi_cs_o, 4'hF);
        chk("ar_gnt_low", gnt_o, 2'b00);
        chk("ar_sck", spi_sck_o, 1'b0);
        chk("ar_cipo", req_cipo_o, 2'b00);
        tick();
        rst_ni = 1'b1;
        req_i = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
